// File: rtl/comparador_pkg.sv
// Shared types and constants for the left-to-right bit-serial magnitude comparator.
package comparador_pkg;

    localparam int COMP_N = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/comparador_bit.sv
// Combinational 1-bit comparison cell: greater-than and not-equal for one bit pair.
module comparador_bit (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic ne
);

    assign gt = a & ~b;
    assign ne = a ^ b;

endmodule

// File: rtl/comparador_serial_izq_der.sv
// Bit-serial unsigned comparator scanning MSB to LSB, reporting A>B and A==B.
// COMPARADOR_EARLY_EXIT_EN: stop at the first differing bit; otherwise latency is always N+1 cycles.
module comparador_serial_izq_der
    import comparador_pkg::*;
#(
    parameter  int N     = COMP_N,
    localparam int IDX_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         Z_out,
    output logic         EQ
);

    state_t           state;
    logic [N-1:0]     ra;
    logic [N-1:0]     rb;
    logic [IDX_W-1:0] idx;
    logic             bit_gt;
    logic             bit_ne;

`ifndef COMPARADOR_EARLY_EXIT_EN
    logic             decided;
    logic             decided_gt;
`endif

    comparador_bit u_bit (
        .a  (ra[idx]),
        .b  (rb[idx]),
        .gt (bit_gt),
        .ne (bit_ne)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Z_out <= 1'b0;
            EQ    <= 1'b0;
            idx   <= '0;
            ra    <= '0;
            rb    <= '0;
`ifndef COMPARADOR_EARLY_EXIT_EN
            decided    <= 1'b0;
            decided_gt <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= A;
                        rb    <= B;
                        idx   <= IDX_W'(N - 1);
                        Z_out <= 1'b0;
                        EQ    <= 1'b0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= SCAN;
`ifndef COMPARADOR_EARLY_EXIT_EN
                        decided    <= 1'b0;
                        decided_gt <= 1'b0;
`endif
                    end
                end
                SCAN: begin
`ifdef COMPARADOR_EARLY_EXIT_EN
                    if (bit_ne) begin
                        Z_out <= bit_gt;
                        EQ    <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (idx == '0) begin
                        Z_out <= 1'b0;
                        EQ    <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
`else
                    // Only the first differing bit counts; the walk always reaches bit 0.
                    if (idx == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                        if (decided) begin
                            Z_out <= decided_gt;
                            EQ    <= 1'b0;
                        end else if (bit_ne) begin
                            Z_out <= bit_gt;
                            EQ    <= 1'b0;
                        end else begin
                            Z_out <= 1'b0;
                            EQ    <= 1'b1;
                        end
                    end else begin
                        if (!decided && bit_ne) begin
                            decided    <= 1'b1;
                            decided_gt <= bit_gt;
                        end
                        idx <= idx - 1'b1;
                    end
`endif
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Self-checking bench for comparador_serial_izq_der against a magnitude/latency reference model.
module tb_comparador_serial_izq_der;

    localparam int N      = 16;
    localparam int BUDGET = 2 * N + 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic         Z_out;
    logic         EQ;

    int vectors;
    int miscompares;

    comparador_serial_izq_der #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Z_out (Z_out),
        .EQ    (EQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle in which done is expected, counting the accept edge as edge 0.
    function automatic int expLatency(logic [N-1:0] a, logic [N-1:0] b);
        logic [N-1:0] diff;
        int lat;
        diff = a ^ b;
        lat  = N + 1;
`ifdef COMPARADOR_EARLY_EXIT_EN
        for (int i = 0; i < N; i++) begin
            if (diff[i]) lat = N - i + 1;
        end
`else
        if (diff != '0) lat = N + 1;
`endif
        return lat;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Starts from IDLE, waits for done and checks latency, result, busy and the hold cycle after.
    task automatic runCompare(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
        int cyc;
        int busy_low;
        logic exp_gt;
        logic exp_eq;
        exp_gt   = (a > b);
        exp_eq   = (a == b);
        busy_low = 0;
        applyStimulus(a, b);
        cyc = 1;
        while (!done && cyc < BUDGET) begin
            if (!busy) busy_low++;
            tick();
            cyc++;
        end
        checkOutput({tag, " done_seen"}, 32'(done), 32'd1);
        checkOutput({tag, " latency"}, 32'(cyc), 32'(expLatency(a, b)));
        checkOutput({tag, " busy_during_scan_low"}, 32'(busy_low), 32'd0);
        checkOutput({tag, " busy_in_done"}, 32'(busy), 32'd1);
        checkOutput({tag, " Z_out"}, 32'(Z_out), 32'(exp_gt));
        checkOutput({tag, " EQ"}, 32'(EQ), 32'(exp_eq));
        tick();
        checkOutput({tag, " done_pulse_end"}, 32'(done), 32'd0);
        checkOutput({tag, " busy_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, " Z_out_hold"}, 32'(Z_out), 32'(exp_gt));
        checkOutput({tag, " EQ_hold"}, 32'(EQ), 32'(exp_eq));
    endtask

    initial begin
        int cyc;
        int done_count;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset Z_out", 32'(Z_out), 32'd0);
        checkOutput("reset EQ", 32'(EQ), 32'd0);
        rst = 1'b0;
        tick();

        runCompare("msb_diff", 16'h8000, 16'h7FFF);
        runCompare("lsb_diff", 16'h0001, 16'h0000);
        runCompare("equal", 16'hA5A5, 16'hA5A5);

        // Start held high and A changed mid-scan must not disturb the running comparison.
        applyStimulus(16'h1234, 16'h1235);
        A          = 16'hFFFF;
        start      = 1'b1;
        cyc        = 1;
        done_count = 0;
        while (!done && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        if (done) done_count++;
        checkOutput("busy_start latency", 32'(cyc), 32'(expLatency(16'h1234, 16'h1235)));
        checkOutput("busy_start Z_out", 32'(Z_out), 32'd0);
        checkOutput("busy_start EQ", 32'(EQ), 32'd0);
        start = 1'b0;
        tick();
        if (done) done_count++;
        checkOutput("busy_start done_count", 32'(done_count), 32'd1);
        checkOutput("busy_start idle", 32'(busy), 32'd0);
        runCompare("back_to_back", 16'hFFFF, 16'h1235);

        // Reset in the middle of a scan.
        applyStimulus(16'h0F00, 16'h0E00);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst done", 32'(done), 32'd0);
        checkOutput("midrst Z_out", 32'(Z_out), 32'd0);
        checkOutput("midrst EQ", 32'(EQ), 32'd0);
        done_count = 0;
        for (int i = 0; i < N + 4; i++) begin
            tick();
            if (done) done_count++;
        end
        checkOutput("midrst no_done", 32'(done_count), 32'd0);
        runCompare("after_rst", 16'h0F00, 16'h0E00);

        for (int i = 0; i < 10; i++) begin
            ra = N'($urandom);
            rb = (i == 4) ? ra : N'($urandom);
            runCompare($sformatf("rand%0d", i), ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
